// File: rtl/fma64_result_checker_if.sv
// Expected-vector and DUT-result channels plus checker status for fma64_result_checker.
interface fma64_result_checker_if #(
    parameter int unsigned CNT_W = 32
);
    logic             clear;

    logic             exp_valid;
    logic             exp_ready;
    logic [63:0]      exp_z;
    logic [4:0]       exp_flags;

    logic             res_valid;
    logic [64:0]      res_z;
    logic [4:0]       res_flags;

    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic [CNT_W-1:0] orphan_count;
    logic             halted;

    logic             first_fail_valid;
    logic [CNT_W-1:0] first_fail_index;
    logic [63:0]      first_fail_got_z;
    logic [63:0]      first_fail_exp_z;
    logic [4:0]       first_fail_got_flags;
    logic [4:0]       first_fail_exp_flags;

    // Stimulus / vector source side
    modport master (
        output clear, exp_valid, exp_z, exp_flags, res_valid, res_z, res_flags,
        input  exp_ready, pass_count, fail_count, orphan_count, halted,
               first_fail_valid, first_fail_index, first_fail_got_z, first_fail_exp_z,
               first_fail_got_flags, first_fail_exp_flags
    );

    // Checker side
    modport slave (
        input  clear, exp_valid, exp_z, exp_flags, res_valid, res_z, res_flags,
        output exp_ready, pass_count, fail_count, orphan_count, halted,
               first_fail_valid, first_fail_index, first_fail_got_z, first_fail_exp_z,
               first_fail_got_flags, first_fail_exp_flags
    );
endinterface

// File: rtl/fma64_result_checker.sv
// Result checker for the float64 FMA: queues expected results, decodes recoded
// DUT results, compares in order and keeps pass/fail/orphan counts plus a
// snapshot of the first mismatch.
module fma64_result_checker #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CNT_W        = 32,
    parameter bit          HALT_ON_FAIL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    fma64_result_checker_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // Recoded float64 {s, E[11:0], f[51:0]} to IEEE float64.
    function automatic logic [63:0] decode_recoded(input logic [64:0] r);
        logic        s;
        logic [11:0] e;
        logic [51:0] f;
        logic [52:0] mant;
        logic [11:0] sh;
        logic [63:0] out;
        s    = r[64];
        e    = r[63:52];
        f    = r[51:0];
        mant = {1'b1, f};
        sh   = 12'h402 - e;
        out  = {s, 63'b0};
        if (e[11:9] == 3'b000) begin
            out = {s, 63'b0};
        end else if (e[11:9] == 3'b110) begin
            out = {s, 11'h7FF, 52'b0};
        end else if (e[11:9] == 3'b111) begin
            out = {s, 11'h7FF, 1'b1, f[50:0]};
        end else if (e >= 12'h402) begin
            out = {s, 11'(e - 12'h401), f};
        end else if (e >= 12'h3CE) begin
            out = {s, 11'b0, 52'(mant >> sh)};
        end
        return out;
    endfunction

    function automatic logic is_nan(input logic [63:0] x);
        return (&x[62:52]) && (|x[51:0]);
    endfunction

    state_t           state_q;

    logic [63:0]      mem_z [DEPTH];
    logic [4:0]       mem_f [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [OW-1:0]    count_q;
    logic [OW-1:0]    count_d;

    logic             s1_valid_q;
    logic [63:0]      s1_got_z_q;
    logic [4:0]       s1_got_f_q;
    logic [63:0]      s1_exp_z_q;
    logic [4:0]       s1_exp_f_q;

    logic [CNT_W-1:0] pass_q,   pass_d;
    logic [CNT_W-1:0] fail_q,   fail_d;
    logic [CNT_W-1:0] orphan_q, orphan_d;
    logic             ff_valid_q, ff_valid_d;
    logic [CNT_W-1:0] ff_index_q, ff_index_d;
    logic [63:0]      ff_got_z_q, ff_got_z_d;
    logic [63:0]      ff_exp_z_q, ff_exp_z_d;
    logic [4:0]       ff_got_f_q, ff_got_f_d;
    logic [4:0]       ff_exp_f_q, ff_exp_f_d;

    logic             run;
    logic             full;
    logic             empty;
    logic             push;
    logic             take;
    logic             pop;
    logic             orphan;
    logic             s1_match;
    logic             s1_mismatch;

    // Handshake decisions; exp_ready looks only at occupancy and state.
    assign run          = (state_q == ST_RUN);
    assign full         = (count_q == OW'(DEPTH));
    assign empty        = (count_q == '0);
    assign bus.exp_ready = !full && run;
    assign push         = bus.exp_valid && bus.exp_ready;
    assign take         = run && bus.res_valid;
    assign pop          = take && !empty;
    assign orphan       = take && empty;

    // Stage-2 compare: bit-identical, or both NaN regardless of sign/payload.
    assign s1_match    = ((s1_got_z_q == s1_exp_z_q) || (is_nan(s1_got_z_q) && is_nan(s1_exp_z_q)))
                         && (s1_got_f_q == s1_exp_f_q);
    assign s1_mismatch = s1_valid_q && !s1_match;

    // FIFO occupancy next value.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + OW'(1);
        end else if (pop && !push) begin
            count_d = count_q - OW'(1);
        end
    end

    // Expected-entry storage; pointers reset so stale data is never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_z[wr_ptr_q] <= bus.exp_z;
            mem_f[wr_ptr_q] <= bus.exp_flags;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Stage 1: decoded DUT result paired with the popped expected entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_got_z_q <= '0;
            s1_got_f_q <= '0;
            s1_exp_z_q <= '0;
            s1_exp_f_q <= '0;
        end else if (bus.clear) begin
            s1_valid_q <= 1'b0;
            s1_got_z_q <= '0;
            s1_got_f_q <= '0;
            s1_exp_z_q <= '0;
            s1_exp_f_q <= '0;
        end else begin
            s1_valid_q <= pop;
            if (pop) begin
                s1_got_z_q <= decode_recoded(bus.res_z);
                s1_got_f_q <= bus.res_flags;
                s1_exp_z_q <= mem_z[rd_ptr_q];
                s1_exp_f_q <= mem_f[rd_ptr_q];
            end
        end
    end

    // Saturating counters and first-failure snapshot next values.
    always_comb begin
        pass_d     = pass_q;
        fail_d     = fail_q;
        orphan_d   = orphan_q;
        ff_valid_d = ff_valid_q;
        ff_index_d = ff_index_q;
        ff_got_z_d = ff_got_z_q;
        ff_exp_z_d = ff_exp_z_q;
        ff_got_f_d = ff_got_f_q;
        ff_exp_f_d = ff_exp_f_q;
        if (orphan && (orphan_q != '1)) begin
            orphan_d = orphan_q + CNT_W'(1);
        end
        if (s1_valid_q) begin
            if (s1_match) begin
                if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
            end else begin
                if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_index_d = pass_q + fail_q;
                    ff_got_z_d = s1_got_z_q;
                    ff_exp_z_d = s1_exp_z_q;
                    ff_got_f_d = s1_got_f_q;
                    ff_exp_f_d = s1_exp_f_q;
                end
            end
        end
    end

    // Counter and snapshot registers; clear wins over any update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_q     <= '0;
            fail_q     <= '0;
            orphan_q   <= '0;
            ff_valid_q <= 1'b0;
            ff_index_q <= '0;
            ff_got_z_q <= '0;
            ff_exp_z_q <= '0;
            ff_got_f_q <= '0;
            ff_exp_f_q <= '0;
        end else if (bus.clear) begin
            pass_q     <= '0;
            fail_q     <= '0;
            orphan_q   <= '0;
            ff_valid_q <= 1'b0;
            ff_index_q <= '0;
            ff_got_z_q <= '0;
            ff_exp_z_q <= '0;
            ff_got_f_q <= '0;
            ff_exp_f_q <= '0;
        end else begin
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            orphan_q   <= orphan_d;
            ff_valid_q <= ff_valid_d;
            ff_index_q <= ff_index_d;
            ff_got_z_q <= ff_got_z_d;
            ff_exp_z_q <= ff_exp_z_d;
            ff_got_f_q <= ff_got_f_d;
            ff_exp_f_q <= ff_exp_f_d;
        end
    end

    // Run/halt control: a mismatch halts when enabled, only clear resumes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else if (bus.clear) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:    if (HALT_ON_FAIL && s1_mismatch) state_q <= ST_HALTED;
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.pass_count           = pass_q;
    assign bus.fail_count           = fail_q;
    assign bus.orphan_count         = orphan_q;
    assign bus.halted               = (state_q == ST_HALTED);
    assign bus.first_fail_valid     = ff_valid_q;
    assign bus.first_fail_index     = ff_index_q;
    assign bus.first_fail_got_z     = ff_got_z_q;
    assign bus.first_fail_exp_z     = ff_exp_z_q;
    assign bus.first_fail_got_flags = ff_got_f_q;
    assign bus.first_fail_exp_flags = ff_exp_f_q;

endmodule

// File: doc/fma64_result_checker.md
# fma64_result_checker

Hardware result checker for the double-precision fused multiply-add datapath. It accepts expected results (IEEE float64 plus 5-bit flags) into an in-order FIFO and accepts DUT results in recoded 65-bit format. It decodes each DUT result to IEEE float64, compares it against the oldest expected entry, and keeps pass, fail and orphan counters plus a first-failure snapshot. It is the consuming end of the vector stream that stimulus logic drives into the FMA.

## Interface
- DEPTH, 8, expected-FIFO entries; power of two, ≥2
- CNT_W, 32, width of all counters
- HALT_ON_FAIL, 1, when 1 the first mismatch moves the block to HALTED
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous; empties FIFO and pipeline, zeroes counters and snapshot, returns to RUN
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  = FIFO not full and state RUN
- exp_z  in  64  expected IEEE float64
- exp_flags  in  5  expected exception flags
- res_valid  in  1  DUT result present this cycle; no backpressure
- res_z  in  65  DUT result, recoded float64
- res_flags  in  5  DUT exception flags
- pass_count, fail_count, orphan_count  out  CNT_W  saturating counters
- halted  out  1  state == HALTED
- first_fail_valid  out  1  snapshot holds a mismatch
- first_fail_index  out  CNT_W  compare ordinal of the first mismatch (0-based)
- first_fail_got_z, first_fail_exp_z  out  64  decoded DUT value and expected value
- first_fail_got_flags, first_fail_exp_flags  out  5  DUT flags and expected flags

## Operation
- Reset or clear: FIFO empty, stage valids 0, all counters 0, snapshot 0, state RUN.
- FIFO push: occurs when exp_valid && exp_ready. No full-cycle bypass, so exp_ready stays 0 while full even if a pop happens that cycle.
- Stage 1, in RUN when res_valid:
  - If the FIFO is non-empty, pop the head, decode res_z and register it with the head entry.
  - If the FIFO is empty, increment orphan_count, pop nothing and let nothing enter stage 2.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Decode of res_z = {s, E[11:0], f[51:0]}:
  - E[11:9]=000 → ±0: {s, 63'b0}.
  - E[11:9]=110 → ±Inf: {s, 11'h7FF, 52'b0}.
  - E[11:9]=111 → NaN: {s, 11'h7FF, 1'b1, f[50:0]}.
  - E ≥ 12'h402 → normal: {s, (E−12'h401)[10:0], f}.
  - 12'h3CE ≤ E ≤ 12'h401 → subnormal: {s, 11'b0, ({1'b1,f} >> (12'h402−E))[51:0]}.
  - Any other E (non-canonical) → decode as ±0, which then counts as a mismatch against any nonzero expected value.
- Stage 2 compare: match = value-equal && flags-equal.
  - value-equal if the 64-bit words are identical, or both are NaN (exponent all ones, fraction ≠ 0), ignoring sign and payload.
  - On match, pass_count+1. On mismatch, fail_count+1; if first_fail_valid is 0, load the snapshot with index = pass_count+fail_count before increment, and set first_fail_valid.
- States: RUN → HALTED on a mismatch at stage 2 when HALT_ON_FAIL=1. HALTED → RUN only on clear.
- In HALTED:
  - exp_ready=0.
  - res_valid is ignored entirely; no orphan is counted.
  - A result already in stage 1 still completes its compare and counts.
  - Counters and snapshot hold.
- All counters saturate at all-ones.
- clear has priority over every other event in the same cycle.

## Timing
- res_valid sampled at edge N → stage-1 register at N → counters and snapshot updated at edge N+1, visible the cycle after.
- The orphan counter updates at edge N.
- Fully pipelined; one result per cycle is sustainable.
- exp_ready is combinational from FIFO occupancy and state only, with no path from exp_valid.
- Reset is asynchronous and may assert mid-stream. Any in-flight stage-1 compare is discarded and not counted.

## Test plan
- Push exp_z=3FF0000000000000, exp_flags=0; drive res_z = recode of 1.0 {0, 12'h800, 52'b0}, res_flags=0 → pass_count=1 two edges later, fail_count=0.
- Subnormal: expected 0000000000000001; res_z E=12'h3CE, f=0 → pass. Change expected to 0000000000000002 → fail_count=1, first_fail_index=1, first_fail_got_z=0000000000000001.
- NaN: expected 7FF8000000000000; DUT E=12'hE00, s=1, f=5 → pass. Expected +Inf vs DUT NaN → fail.
- Fill FIFO with DEPTH entries → exp_ready=0. Then push and result in the same cycle at full: result pops, push is refused that cycle, exp_ready=1 next cycle.
- res_valid with empty FIFO, 3 cycles → orphan_count=3, pass and fail unchanged.
- HALT_ON_FAIL=1: mismatch then 4 more results → halted=1, fail_count=1, later results ignored, exp_ready=0. Pulse clear → all zero, RUN. Also assert reset mid-stream → all outputs zero immediately.
